// File: rtl/counter_monitor_pkg.sv
// Shared definitions for the counter monitor: cause bit positions, the
// cause vector type and the interrupt handshake state encoding.
package counter_pkg;

    // Bit positions inside the 3-bit cause / event vector
    localparam int CAUSE_OVF = 0;
    localparam int CAUSE_UNF = 1;
    localparam int CAUSE_CMP = 2;

    // One bit per interrupt source, ordered by the indices above
    typedef logic [2:0] cause_t;

    // Four-phase request/acknowledge handshake states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } irq_state_t;

endpackage

// File: rtl/counter_monitor_irq_handshake.sv
// Interrupt delivery: collects single-cycle events into a pending set and
// presents them to the interrupt controller over a 4-phase req/ack handshake.
// Events that arrive while a request is in flight stay pending and go out
// with the following request, so nothing is ever lost.
module irq_handshake
    import counter_pkg::*;
(
    input  logic   Clock,
    input  logic   Reset_n,
    input  cause_t Event_in,
    input  logic   Irq_ack,
    output logic   Irq_req,
    output cause_t Irq_cause
);

    irq_state_t state;
    cause_t     pending;
    cause_t     cause_q;

    // Pending accumulation, cause latching and handshake sequencing
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state   <= IDLE;
            pending <= '0;
            cause_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        cause_q <= pending;
                        pending <= Event_in;
                        state   <= REQ;
                    end else begin
                        pending <= pending | Event_in;
                    end
                end
                REQ: begin
                    pending <= pending | Event_in;
                    if (Irq_ack) begin
                        state <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    pending <= pending | Event_in;
                    if (!Irq_ack) begin
                        state   <= IDLE;
                        cause_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cause_q <= '0;
                end
            endcase
        end
    end

    // Request is asserted only in REQ; the cause register is already zero in IDLE
    always_comb begin
        Irq_req   = (state == REQ);
        Irq_cause = cause_q;
    end

endmodule

// File: rtl/counter_monitor.sv
// Consumer side of the up/down counter interface. Captures the counter value,
// turns the level-style wrap flags into single events, keeps an epoch count of
// wraps so {epoch, count} forms one coherent extended count, and forwards
// overflow/underflow/compare events to the interrupt handshake.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int N = 17,
    parameter int E = 8
) (
    input  logic           Clock,
    input  logic           Reset_n,
    input  logic [N-1:0]   Count_in,
    input  logic           Overflow_in,
    input  logic           Underflow_in,
    input  logic [N-1:0]   Compare_val,
    input  logic           Compare_en,
    input  logic           Irq_ack,
    output logic [N+E-1:0] Ext_count,
    output logic [E-1:0]   Epoch_out,
    output logic           Irq_req,
    output logic [2:0]     Irq_cause,
    output logic           Epoch_err
);

    logic [N-1:0] count_q;
    logic [E-1:0] epoch;
    logic         ov_d;
    logic         un_d;
    logic         cmp_d;
    logic         epoch_err_q;

    logic         cmp_level;
    logic         ov_evt;
    logic         un_evt;
    logic         cmp_evt;
    cause_t       events;
    cause_t       cause_w;

    // Rising-edge detection on the raw flag levels and the compare match
    always_comb begin
        cmp_level = Compare_en & (Count_in == Compare_val);
        ov_evt    = Overflow_in & ~ov_d;
        un_evt    = Underflow_in & ~un_d;
        cmp_evt   = cmp_level & ~cmp_d;
        events            = '0;
        events[CAUSE_OVF] = ov_evt;
        events[CAUSE_UNF] = un_evt;
        events[CAUSE_CMP] = cmp_evt;
    end

    // Count capture, edge history and epoch updated together so the extended count is never torn
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count_q     <= '0;
            epoch       <= '0;
            ov_d        <= 1'b0;
            un_d        <= 1'b0;
            cmp_d       <= 1'b0;
            epoch_err_q <= 1'b0;
        end else begin
            count_q <= Count_in;
            ov_d    <= Overflow_in;
            un_d    <= Underflow_in;
            cmp_d   <= cmp_level;
            if (ov_evt && !un_evt) begin
                epoch <= epoch + E'(1);
            end else if (un_evt && !ov_evt) begin
                epoch <= epoch - E'(1);
            end
            if ((ov_evt && (epoch == {E{1'b1}})) || (un_evt && (epoch == '0))) begin
                epoch_err_q <= 1'b1;
            end
        end
    end

    irq_handshake u_irq_handshake (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Event_in  (events),
        .Irq_ack   (Irq_ack),
        .Irq_req   (Irq_req),
        .Irq_cause (cause_w)
    );

    // Output assembly
    always_comb begin
        Ext_count = {epoch, count_q};
        Epoch_out = epoch;
        Irq_cause = cause_w;
        Epoch_err = epoch_err_q;
    end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor: reset behaviour, capture
// latency, flag edge detection, epoch wrap, epoch error, compare events and
// the 4-phase interrupt handshake including reset in the middle of it.
module tb_counter_monitor;

    localparam int N = 17;
    localparam int E = 8;

    logic           Clock;
    logic           Reset_n;
    logic [N-1:0]   Count_in;
    logic           Overflow_in;
    logic           Underflow_in;
    logic [N-1:0]   Compare_val;
    logic           Compare_en;
    logic           Irq_ack;
    logic [N+E-1:0] Ext_count;
    logic [E-1:0]   Epoch_out;
    logic           Irq_req;
    logic [2:0]     Irq_cause;
    logic           Epoch_err;

    int checks;
    int failures;

    counter_monitor #(.N(N), .E(E)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Count_in     (Count_in),
        .Overflow_in  (Overflow_in),
        .Underflow_in (Underflow_in),
        .Compare_val  (Compare_val),
        .Compare_en   (Compare_en),
        .Irq_ack      (Irq_ack),
        .Ext_count    (Ext_count),
        .Epoch_out    (Epoch_out),
        .Irq_req      (Irq_req),
        .Irq_cause    (Irq_cause),
        .Epoch_err    (Epoch_err)
    );

    // 10 ns clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic applyStimulus(input logic rstN, input logic [N-1:0] cnt,
                                 input logic ov, input logic un, input logic ack);
        Reset_n      = rstN;
        Count_in     = cnt;
        Overflow_in  = ov;
        Underflow_in = un;
        Irq_ack      = ack;
        @(posedge Clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        checks      = 0;
        failures    = 0;
        Compare_val = '0;
        Compare_en  = 1'b0;

        // Reset with a nonzero count on the input
        applyStimulus(1'b0, 17'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 17'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_ext",   32'(Ext_count), 32'h0);
        checkOutput("rst_req",   32'(Irq_req),   32'h0);
        checkOutput("rst_cause", 32'(Irq_cause), 32'h0);
        checkOutput("rst_err",   32'(Epoch_err), 32'h0);
        checkOutput("rst_epoch", 32'(Epoch_out), 32'h0);

        // Released: count appears one cycle later
        applyStimulus(1'b1, 17'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("cap_5", 32'(Ext_count), 32'h5);
        applyStimulus(1'b1, 17'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("cap_0", 32'(Ext_count), 32'h0);

        // Overflow level held four cycles with the counter parked at zero
        applyStimulus(1'b1, 17'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("ov_epoch1",  32'(Epoch_out), 32'h1);
        checkOutput("ov_noreq",   32'(Irq_req),   32'h0);
        applyStimulus(1'b1, 17'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("ov_req",     32'(Irq_req),   32'h1);
        checkOutput("ov_cause",   32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 17'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("ov_once",    32'(Epoch_out), 32'h1);
        checkOutput("ov_reqhold", 32'(Irq_req),   32'h1);
        applyStimulus(1'b1, 17'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ack_reqlow",  32'(Irq_req),   32'h0);
        checkOutput("ack_cause",   32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ackl_cause",  32'(Irq_cause), 32'h0);
        applyStimulus(1'b1, 17'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_noreq",  32'(Irq_req),   32'h0);

        // Up-wrap then immediate down-wrap from a fresh epoch
        applyStimulus(1'b0, 17'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_top",  32'(Ext_count), 32'h0001FFFF);
        applyStimulus(1'b1, 17'h00000, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_up",   32'(Ext_count), 32'h00020000);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_down", 32'(Ext_count), 32'h0001FFFF);
        checkOutput("wrap_err0", 32'(Epoch_err), 32'h0);
        checkOutput("wrap_req",  32'(Irq_req),   32'h1);
        checkOutput("wrap_c1",   32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_req2", 32'(Irq_req),   32'h1);
        checkOutput("wrap_c2",   32'(Irq_cause), 32'h2);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0);

        // Underflow at epoch zero wraps the epoch and raises the sticky error
        applyStimulus(1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b0);
        checkOutput("unf_epoch", 32'(Epoch_out), 32'hFF);
        checkOutput("unf_err",   32'(Epoch_err), 32'h1);
        checkOutput("unf_ext",   32'(Ext_count), 32'h01FFFFFF);
        applyStimulus(1'b1, 17'h00000, 1'b1, 1'b0, 1'b0);
        checkOutput("ret_epoch", 32'(Epoch_out), 32'h0);
        checkOutput("ret_err",   32'(Epoch_err), 32'h1);
        checkOutput("ret_cause", 32'(Irq_cause), 32'h2);
        applyStimulus(1'b1, 17'h00000, 1'b0, 1'b0, 1'b0);
        checkOutput("err_hold",  32'(Epoch_err), 32'h1);

        // Compare event arriving while an overflow request is outstanding
        applyStimulus(1'b0, 17'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_err", 32'(Epoch_err), 32'h0);
        Compare_en  = 1'b1;
        Compare_val = 17'd100;
        applyStimulus(1'b1, 17'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 17'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp_req1",   32'(Irq_req),   32'h1);
        checkOutput("cmp_c1",     32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp_hold",   32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        checkOutput("cmp_wait",   32'(Irq_req),   32'h0);
        checkOutput("cmp_waitc",  32'(Irq_cause), 32'h1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp_idle",   32'(Irq_req),   32'h0);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp_req2",   32'(Irq_req),   32'h1);
        checkOutput("cmp_c2",     32'(Irq_cause), 32'h4);

        // Reset in the middle of the handshake while acknowledge stays high
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        checkOutput("wl_cause",   32'(Irq_cause), 32'h4);
        Compare_en = 1'b0;
        applyStimulus(1'b0, 17'd100, 1'b0, 1'b0, 1'b1);
        checkOutput("mrst_req",   32'(Irq_req),   32'h0);
        checkOutput("mrst_cause", 32'(Irq_cause), 32'h0);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 17'd100, 1'b0, 1'b0, 1'b1);
        checkOutput("quiet_req",  32'(Irq_req),   32'h0);
        checkOutput("quiet_ext",  32'(Ext_count), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
